// File: rtl/tv_key_lock_fsm.sv
// Time-varying key lock owning a host FSM's present-state register.
// A rotating key schedule gates nx_state; misses load decoys or lock out.
module tv_key_lock_fsm #(
  parameter int STATE_W = 4,
  parameter int KEY_W = 5,
  parameter int NUM_KEYS = 2,
  parameter int WINDOW = 2,
  parameter logic [NUM_KEYS*KEY_W-1:0] KEYS = 10'h107,
  parameter logic [NUM_KEYS*STATE_W-1:0] DECOYS = 8'h56,
  parameter logic [STATE_W-1:0] RESET_STATE = 4'd1,
  parameter int LOCKOUT_THR = 0,
  parameter logic [STATE_W-1:0] LOCKOUT_STATE = 4'd0,
  localparam int WI_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic [KEY_W-1:0] key_i,
  input  logic [STATE_W-1:0] nx_state_i,
  output logic [STATE_W-1:0] pr_state_o,
  output logic [WI_W-1:0] win_idx_o,
  output logic key_ok_o,
  output logic [7:0] err_cnt_o,
  output logic locked_out_o
);

  localparam int SC_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  logic [SC_W-1:0] sub_cnt;
  logic [SC_W-1:0] sub_nx;
  logic [WI_W-1:0] win_nx;
  logic bad;
  logic bad_nx;
  logic [KEY_W-1:0] key_sel;
  logic [STATE_W-1:0] decoy;
  logic [STATE_W-1:0] pr_nx;
  logic match;
  logic last;
  logic bad_win;
  logic [7:0] err_inc;
  logic [7:0] err_nx;
  logic lock_nx;

  always_comb begin
    key_sel = KEYS[int'(win_idx_o)*KEY_W +: KEY_W];
    decoy = DECOYS[int'(win_idx_o)*STATE_W +: STATE_W];
    match = (key_i == key_sel);
    last = (sub_cnt == SC_W'(WINDOW - 1));
    bad_win = bad | ~match;
    err_inc = (err_cnt_o == 8'hFF) ? 8'hFF : err_cnt_o + 8'd1;

    sub_nx = sub_cnt + SC_W'(1);
    win_nx = win_idx_o;
    bad_nx = bad_win;
    err_nx = err_cnt_o;
    if (last) begin
      sub_nx = '0;
      bad_nx = 1'b0;
      err_nx = bad_win ? err_inc : 8'd0;
      if (win_idx_o == WI_W'(NUM_KEYS - 1))
        win_nx = '0;
      else
        win_nx = win_idx_o + WI_W'(1);
    end

    // lockout sees the freshly updated count on the window-end edge
    lock_nx = locked_out_o;
    if (LOCKOUT_THR != 0 && last && int'(err_nx) >= LOCKOUT_THR)
      lock_nx = 1'b1;

    if (locked_out_o)
      pr_nx = LOCKOUT_STATE;
    else if (match)
      pr_nx = nx_state_i;
    else
      pr_nx = decoy;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sub_cnt <= '0;
      win_idx_o <= '0;
      pr_state_o <= RESET_STATE;
      key_ok_o <= 1'b0;
      err_cnt_o <= 8'd0;
      locked_out_o <= 1'b0;
      bad <= 1'b0;
    end else begin
      sub_cnt <= sub_nx;
      win_idx_o <= win_nx;
      pr_state_o <= pr_nx;
      key_ok_o <= match & ~locked_out_o;
      err_cnt_o <= err_nx;
      locked_out_o <= lock_nx;
      bad <= bad_nx;
    end
  end

endmodule

// File: tb/tb_tv_key_lock_fsm.sv
// Bench for tv_key_lock_fsm: three configurations against a
// cycle-count based reference model, plus directed literal pins.
module tb_tv_key_lock_fsm;

  typedef struct {
    int t;
    bit bad;
    int err;
    bit lk;
    int pr;
    bit ok;
  } ms_t;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] key_a;
  logic [7:0] key_c;
  logic [3:0] nx_state;

  logic [3:0] pr_a, pr_b, pr_c;
  logic [0:0] win_a, win_b;
  logic [1:0] win_c;
  logic ok_a, ok_b, ok_c;
  logic [7:0] err_a, err_b, err_c;
  logic lk_a, lk_b, lk_c;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 0;
  ms_t ma, mb, mc;

  int ka[2] = '{7, 8};
  int da[2] = '{6, 5};
  int kc[4] = '{8'h0F, 8'h81, 8'h3C, 8'hA5};
  int dc[4] = '{7, 10, 12, 9};
  int win1[8] = '{0, 1, 1, 0, 0, 1, 1, 0};
  int wc[13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};

  always #5 clk = ~clk;

  tv_key_lock_fsm dut_a (
    .clk(clk), .rst(rst), .key_i(key_a), .nx_state_i(nx_state),
    .pr_state_o(pr_a), .win_idx_o(win_a), .key_ok_o(ok_a),
    .err_cnt_o(err_a), .locked_out_o(lk_a)
  );

  tv_key_lock_fsm #(.LOCKOUT_THR(3)) dut_b (
    .clk(clk), .rst(rst), .key_i(key_a), .nx_state_i(nx_state),
    .pr_state_o(pr_b), .win_idx_o(win_b), .key_ok_o(ok_b),
    .err_cnt_o(err_b), .locked_out_o(lk_b)
  );

  tv_key_lock_fsm #(
    .STATE_W(4), .KEY_W(8), .NUM_KEYS(4), .WINDOW(3),
    .KEYS(32'hA53C810F), .DECOYS(16'h9CA7),
    .RESET_STATE(4'd2), .LOCKOUT_THR(2), .LOCKOUT_STATE(4'hF)
  ) dut_c (
    .clk(clk), .rst(rst), .key_i(key_c), .nx_state_i(nx_state),
    .pr_state_o(pr_c), .win_idx_o(win_c), .key_ok_o(ok_c),
    .err_cnt_o(err_c), .locked_out_o(lk_c)
  );

  function automatic void chk(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int win(int t, int w, int nk);
    return (t / w) % nk;
  endfunction

  function automatic ms_t step(ms_t m, bit r, int rs, int w, int nk,
                               int thr, int lks, bit mt, int nx, int dec);
    ms_t n = m;
    if (r) begin
      n.t = 0; n.bad = 0; n.err = 0; n.lk = 0; n.pr = rs; n.ok = 0;
      return n;
    end
    n.pr = m.lk ? lks : (mt ? nx : dec);
    n.ok = mt && !m.lk;
    if (m.t % w == w - 1) begin
      if (m.bad || !mt) n.err = (m.err < 255) ? m.err + 1 : 255;
      else n.err = 0;
      n.bad = 0;
      if (thr != 0 && n.err >= thr) n.lk = 1;
    end else begin
      n.bad = m.bad || !mt;
    end
    n.t = (m.t + 1) % (w * nk);
    return n;
  endfunction

  function automatic logic [4:0] good_a();
    return 5'(ka[win(ma.t, 2, 2)]);
  endfunction

  function automatic logic [7:0] good_c();
    return 8'(kc[win(mc.t, 3, 4)]);
  endfunction

  task automatic cyc(input bit r, input logic [4:0] k5,
                     input logic [7:0] k8, input logic [3:0] nx);
    ms_t na, nb, nc;
    int wa, wcc;
    rst = r; key_a = k5; key_c = k8; nx_state = nx;
    wa = win(ma.t, 2, 2);
    wcc = win(mc.t, 3, 4);
    na = step(ma, r, 1, 2, 2, 0, 0, int'(k5) == ka[wa], int'(nx), da[wa]);
    nb = step(mb, r, 1, 2, 2, 3, 0, int'(k5) == ka[wa], int'(nx), da[wa]);
    nc = step(mc, r, 2, 3, 4, 2, 15, int'(k8) == kc[wcc], int'(nx), dc[wcc]);
    @(posedge clk);
    #1;
    ma = na; mb = nb; mc = nc;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_pr", int'(pr_a), ma.pr);
      chk("a_win", int'(win_a), win(ma.t, 2, 2));
      chk("a_ok", int'(ok_a), int'(ma.ok));
      chk("a_err", int'(err_a), ma.err);
      chk("a_lk", int'(lk_a), int'(ma.lk));
      chk("b_pr", int'(pr_b), mb.pr);
      chk("b_win", int'(win_b), win(mb.t, 2, 2));
      chk("b_ok", int'(ok_b), int'(mb.ok));
      chk("b_err", int'(err_b), mb.err);
      chk("b_lk", int'(lk_b), int'(mb.lk));
      chk("c_pr", int'(pr_c), mc.pr);
      chk("c_win", int'(win_c), win(mc.t, 3, 4));
      chk("c_ok", int'(ok_c), int'(mc.ok));
      chk("c_err", int'(err_c), mc.err);
      chk("c_lk", int'(lk_c), int'(mc.lk));
    end
  end

  initial begin
    logic [4:0] k5;
    logic [7:0] k8;
    rst = 1'b1; key_a = '0; key_c = '0; nx_state = '0;
    ma = '{default: 0}; mb = '{default: 0}; mc = '{default: 0};
    #2;
    cyc(1, 0, 0, 0);
    chk_en = 1;
    chk("rst_pr", int'(pr_a), 1);
    chk("rst_ok", int'(ok_a), 0);
    chk("rst_err", int'(err_a), 0);
    chk("rst_c_pr", int'(pr_c), 2);

    for (int i = 0; i < 8; i++) begin
      cyc(0, good_a(), good_c(), 4'd3);
      chk("t1_pr", int'(pr_a), 3);
      chk("t1_ok", int'(ok_a), 1);
      chk("t1_err", int'(err_a), 0);
      chk("t1_win", int'(win_a), win1[i]);
    end

    cyc(1, 0, 0, 0);
    cyc(0, 5'd0, good_c(), 4'd3);
    chk("t2_pr0", int'(pr_a), 6);
    chk("t2_err0", int'(err_a), 0);
    cyc(0, 5'd0, good_c(), 4'd3);
    chk("t2_pr1", int'(pr_a), 6);
    chk("t2_err1", int'(err_a), 1);
    cyc(0, good_a(), good_c(), 4'd3);
    chk("t2_pr2", int'(pr_a), 3);
    chk("t2_err2", int'(err_a), 1);
    cyc(0, good_a(), good_c(), 4'd3);
    chk("t2_err3", int'(err_a), 0);

    cyc(1, 0, 0, 0);
    cyc(0, good_a(), good_c(), 4'd3);
    cyc(0, good_a(), good_c(), 4'd3);
    cyc(0, 5'b00111, good_c(), 4'd3);
    chk("t3_pr2", int'(pr_a), 5);
    chk("t3_ok2", int'(ok_a), 0);
    cyc(0, 5'b00111, good_c(), 4'd3);
    chk("t3_pr3", int'(pr_a), 5);
    chk("t3_err3", int'(err_a), 1);

    cyc(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 5'd0, good_c(), 4'd3);
      if (i == 1) chk("t4_err1", int'(err_b), 1);
      if (i == 3) chk("t4_err2", int'(err_b), 2);
      if (i == 3) chk("t4_lk_pre", int'(lk_b), 0);
    end
    chk("t4_err3", int'(err_b), 3);
    chk("t4_lk", int'(lk_b), 1);
    chk("t4_pr_dec", int'(pr_b), 6);
    for (int i = 0; i < 4; i++) begin
      cyc(0, good_a(), good_c(), 4'd3);
      chk("t4_pr_lock", int'(pr_b), 0);
      chk("t4_ok_lock", int'(ok_b), 0);
      chk("t4_lk_hold", int'(lk_b), 1);
      chk("t4_a_pr", int'(pr_a), 3);
    end

    cyc(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 5'd0, good_c(), 4'd3);
    chk("t5_err_pre", int'(err_a), 2);
    cyc(1, 0, 0, 4'd3);
    chk("t5_pr", int'(pr_a), 1);
    chk("t5_win", int'(win_a), 0);
    chk("t5_err", int'(err_a), 0);
    chk("t5_lk_b", int'(lk_b), 0);
    cyc(0, good_a(), good_c(), 4'd3);
    chk("t5_pr1", int'(pr_a), 3);
    chk("t5_win1", int'(win_a), 0);
    cyc(0, good_a(), good_c(), 4'd3);
    chk("t5_win2", int'(win_a), 1);

    cyc(1, 0, 0, 0);
    for (int i = 0; i < 13; i++) begin
      chk("t6_win", int'(win_c), wc[i]);
      k8 = (i == 4) ? ~good_c() : good_c();
      cyc(0, good_a(), k8, 4'd3);
      if (i == 4) chk("t6_pr_dec", int'(pr_c), 10);
      if (i == 5) chk("t6_err", int'(err_c), 1);
      if (i == 5) chk("t6_lk", int'(lk_c), 0);
      if (i == 8) chk("t6_err_clr", int'(err_c), 0);
    end

    for (int i = 0; i < 3000; i++) begin
      k5 = ($urandom_range(0, 99) < 80) ? good_a() : 5'($urandom);
      k8 = ($urandom_range(0, 99) < 85) ? good_c() : 8'($urandom);
      cyc($urandom_range(0, 199) == 0, k5, k8, 4'($urandom));
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
